mat_mult_seq: RTL and testbench

- Address/strobe sequencer for the shared MAC datapath of the matrix-multiply unit.
- Walks C = A x B for square N x N operands held in two single-port read RAMs, with 1-cycle read latency.
- Emits RAM read addresses, MAC enable/clear strobes and result-write strobes, with a start/done handshake toward the top-level controller.
- Supports a memory stall input and an abort input.

---
 rtl/mat_mult_seq.sv | 171 +++++++++++++++++
 tb/tb_mat_mult_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mult_seq.sv
// Address/strobe sequencer for the shared MAC datapath of the matrix-multiply
// unit. Walks C = A x B over N x N operands, issuing A/B read addresses,
// MAC accumulate/clear strobes and C write strobes, with a start/done
// handshake and stall/abort support. Every output is registered.
module mat_mult_seq #(
  parameter int N      = 8,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] addr_c,
  output logic [CNT_W-1:0]  clock_count
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic             flush_cnt;
  logic [IDX_W-1:0] i;
  logic [IDX_W-1:0] j;
  logic [IDX_W-1:0] k;

  logic issue;
  logic last_issue;
  logic accept;
  logic busy_nxt;
  logic done_nxt;

  // Stage-1 side information travelling with each read
  logic               rd_kz;
  logic               rd_kl;
  logic [2*IDX_W-1:0] rd_c;

  // Stage-2 side information travelling with each MAC strobe
  logic               mac_last;
  logic [2*IDX_W-1:0] mac_c;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next_state = RUN;
        RUN:     if (issue && last_issue) next_state = FLUSH;
        FLUSH:   if (flush_cnt) next_state = DONE;
        DONE:    if (!start) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Output-side decode feeding the registered strobes
  always_comb begin
    issue      = (state == RUN) && !stall;
    last_issue = (i == LAST) && (j == LAST) && (k == LAST);
    accept     = (state == IDLE) && start && !abort;
    busy_nxt   = !abort && ((next_state == RUN) || (next_state == FLUSH));
    done_nxt   = !abort && (state == DONE);
  end

  // Two-cycle drain timer while in FLUSH
  always_ff @(posedge clk) begin
    if (!reset)               flush_cnt <= 1'b0;
    else if (state == FLUSH)  flush_cnt <= 1'b1;
    else                      flush_cnt <= 1'b0;
  end

  // Loop indices: k innermost, then j, then i; frozen while stalled
  always_ff @(posedge clk) begin
    if (!reset) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (accept) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (issue && !abort) begin
      if (k == LAST) begin
        k <= '0;
        if (j == LAST) begin
          j <= '0;
          i <= i + IDX_W'(1);
        end else begin
          j <= j + IDX_W'(1);
        end
      end else begin
        k <= k + IDX_W'(1);
      end
    end
  end

  // Cycle counter covering RUN and FLUSH, held between operations
  always_ff @(posedge clk) begin
    if (!reset)
      clock_count <= '0;
    else if (accept)
      clock_count <= '0;
    else if ((state == RUN) || (state == FLUSH))
      clock_count <= clock_count + CNT_W'(1);
  end

  // Read issue, MAC and write pipeline; stages never stall, abort drops all
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      addr_a   <= '0;
      addr_b   <= '0;
      rd_kz    <= 1'b0;
      rd_kl    <= 1'b0;
      rd_c     <= '0;
      mac_en   <= 1'b0;
      mac_clr  <= 1'b0;
      mac_last <= 1'b0;
      mac_c    <= '0;
      wr_en    <= 1'b0;
      addr_c   <= '0;
    end else begin
      busy     <= busy_nxt;
      done     <= done_nxt;
      rd_en    <= issue && !abort;
      if (issue && !abort) begin
        addr_a <= ADDR_W'({i, k});
        addr_b <= ADDR_W'({k, j});
        rd_kz  <= (k == '0);
        rd_kl  <= (k == LAST);
        rd_c   <= {i, j};
      end
      mac_en   <= rd_en && !abort;
      mac_clr  <= rd_en && rd_kz && !abort;
      mac_last <= rd_en && rd_kl && !abort;
      mac_c    <= rd_c;
      wr_en    <= mac_en && mac_last && !abort;
      if (mac_en && mac_last && !abort)
        addr_c <= ADDR_W'(mac_c);
    end
  end

endmodule

// File: tb/tb_mat_mult_seq.sv
// Self-checking bench for mat_mult_seq: randomized and patterned stalls,
// abort, mid-run reset and start-held handshake, checked against a nested-loop
// reference of the matrix walk.
module tb_mat_mult_seq;

  localparam int N      = 8;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = 11;
  localparam int NN     = N * N;
  localparam int NNN    = N * N * N;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic              stall;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic              mac_en;
  logic              mac_clr;
  logic              wr_en;
  logic [ADDR_W-1:0] addr_c;
  logic [CNT_W-1:0]  clock_count;

  int checks;
  int fails;

  // Observation log of one operation
  int rd_a_q[$];
  int rd_b_q[$];
  int rd_e_q[$];
  int wr_q[$];
  int wr_e_q[$];
  int mac_e_q[$];
  bit mac_clr_q[$];
  int orphan_mac;
  int done_edge;
  int cc_at_done;
  int cc_first;
  int model_last_rd;
  bit snap_zero;
  int snap_cc;

  mat_mult_seq #(.N(N), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .stall(stall),
    .busy(busy),
    .done(done),
    .rd_en(rd_en),
    .addr_a(addr_a),
    .addr_b(addr_b),
    .mac_en(mac_en),
    .mac_clr(mac_clr),
    .wr_en(wr_en),
    .addr_c(addr_c),
    .clock_count(clock_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Starts one operation (start seen at edge 0) and logs outputs edge by edge.
  // stall_mode: 0 none, 1 every third cycle, 2 random. Stops at done or budget.
  task automatic run_op(input int stall_mode, input int abort_edge, input int reset_edge,
                        input bit hold_start, input int max_edges);
    int  model_reads;
    bit  s;
    bit  prev_rd;
    rd_a_q.delete(); rd_b_q.delete(); rd_e_q.delete();
    wr_q.delete(); wr_e_q.delete(); mac_e_q.delete(); mac_clr_q.delete();
    orphan_mac = 0; done_edge = -1; cc_at_done = -1; cc_first = -1;
    model_last_rd = -1; snap_zero = 1'b0; snap_cc = -1;
    model_reads = 0;
    prev_rd = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    for (int e = 1; e <= max_edges; e++) begin
      case (stall_mode)
        1:       s = (e % 3 == 0);
        2:       s = ($urandom % 4 == 0);
        default: s = 1'b0;
      endcase
      stall = s;
      abort = (e == abort_edge);
      reset = (e == reset_edge) ? 1'b0 : 1'b1;
      if (!s && model_reads < NNN) begin
        model_reads++;
        if (model_reads == NNN) model_last_rd = e;
      end
      @(posedge clk);
      #1;
      if (e == 1) cc_first = int'(clock_count);
      if (rd_en) begin
        rd_a_q.push_back(int'(addr_a));
        rd_b_q.push_back(int'(addr_b));
        rd_e_q.push_back(e);
      end
      if (mac_en) begin
        if (!prev_rd) orphan_mac++;
        mac_e_q.push_back(e);
        mac_clr_q.push_back(mac_clr);
      end
      if (mac_clr && !mac_en) orphan_mac++;
      if (wr_en) begin
        wr_q.push_back(int'(addr_c));
        wr_e_q.push_back(e);
      end
      prev_rd = rd_en;
      if (e == reset_edge) begin
        snap_zero = ({busy, done, rd_en, mac_en, mac_clr, wr_en} == 6'b0) &&
                    (addr_a == '0) && (addr_b == '0) && (addr_c == '0);
        snap_cc = int'(clock_count);
      end
      if (done && done_edge < 0) begin
        done_edge  = e;
        cc_at_done = int'(clock_count);
        break;
      end
    end
    stall = 1'b0;
    abort = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    stall = 1'b0;
    idle_cycles(3);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (rd_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_rd_en: got %b expected 0", rd_en); end
    checks++; if ({mac_en, mac_clr, wr_en} !== 3'b0) begin fails++; $display("[TB] FAIL reset_strobes: got %b expected 000", {mac_en, mac_clr, wr_en}); end
    checks++; if (clock_count !== '0) begin fails++; $display("[TB] FAIL reset_count: got %0d expected 0", clock_count); end
    checks++; if ({addr_a, addr_b, addr_c} !== '0) begin fails++; $display("[TB] FAIL reset_addr: got %0d/%0d/%0d expected 0", addr_a, addr_b, addr_c); end
    reset = 1'b1;
    idle_cycles(2);
  endtask

  // One complete operation compared against the nested i/j/k walk
  task automatic test_full_run(input string name, input int stall_mode);
    int bad;
    int obs;
    run_op(stall_mode, -1, -1, 1'b0, 4000);
    checks++; if (rd_a_q.size() != NNN) begin fails++; $display("[TB] FAIL %s_rd_count: got %0d expected %0d", name, rd_a_q.size(), NNN); end
    bad = 0;
    for (int r = 0; r < rd_a_q.size(); r++) begin
      int ii, jj, kk;
      ii = r / NN; jj = (r / N) % N; kk = r % N;
      if (rd_a_q[r] != ii * N + kk || rd_b_q[r] != kk * N + jj) bad++;
    end
    checks++; if (bad != 0) begin fails++; $display("[TB] FAIL %s_rd_order: got %0d bad reads expected 0", name, bad); end
    obs = (rd_a_q.size() > 10) ? rd_a_q[10] * 100 + rd_b_q[10] : -1;
    checks++; if (obs != 2 * 100 + 17) begin fails++; $display("[TB] FAIL %s_read10: got %0d expected %0d (a*100+b)", name, obs, 217); end
    obs = (rd_a_q.size() > 0) ? rd_a_q[rd_a_q.size()-1] * 100 + rd_b_q[rd_b_q.size()-1] : -1;
    checks++; if (obs != (NN - 1) * 100 + (NN - 1)) begin fails++; $display("[TB] FAIL %s_final_read: got %0d expected %0d (a*100+b)", name, obs, (NN - 1) * 101); end
    checks++; if (mac_e_q.size() != NNN) begin fails++; $display("[TB] FAIL %s_mac_count: got %0d expected %0d", name, mac_e_q.size(), NNN); end
    bad = 0;
    for (int m = 0; m < mac_clr_q.size(); m++)
      if (mac_clr_q[m] != (m % N == 0)) bad++;
    checks++; if (bad != 0) begin fails++; $display("[TB] FAIL %s_mac_clr_pattern: got %0d bad expected 0", name, bad); end
    checks++; if (orphan_mac != 0) begin fails++; $display("[TB] FAIL %s_orphan_mac: got %0d expected 0", name, orphan_mac); end
    checks++; if (wr_q.size() != NN) begin fails++; $display("[TB] FAIL %s_wr_count: got %0d expected %0d", name, wr_q.size(), NN); end
    bad = 0;
    for (int w = 0; w < wr_q.size(); w++)
      if (wr_q[w] != w) bad++;
    checks++; if (bad != 0) begin fails++; $display("[TB] FAIL %s_wr_order: got %0d bad expected 0", name, bad); end
    obs = (mac_e_q.size() > 0) ? mac_e_q[mac_e_q.size()-1] : -1;
    checks++; if (obs != model_last_rd + 1) begin fails++; $display("[TB] FAIL %s_last_mac_edge: got %0d expected %0d", name, obs, model_last_rd + 1); end
    obs = (wr_e_q.size() > 0) ? wr_e_q[wr_e_q.size()-1] : -1;
    checks++; if (obs != model_last_rd + 2) begin fails++; $display("[TB] FAIL %s_last_wr_edge: got %0d expected %0d", name, obs, model_last_rd + 2); end
    checks++; if (done_edge != model_last_rd + 3) begin fails++; $display("[TB] FAIL %s_done_edge: got %0d expected %0d", name, done_edge, model_last_rd + 3); end
    checks++; if (cc_at_done != model_last_rd + 2) begin fails++; $display("[TB] FAIL %s_clock_count: got %0d expected %0d", name, cc_at_done, model_last_rd + 2); end
    checks++; if (cc_first != 1) begin fails++; $display("[TB] FAIL %s_count_restart: got %0d expected 1", name, cc_first); end
    if (stall_mode == 0) begin
      checks++; if (done_edge != NNN + 3) begin fails++; $display("[TB] FAIL %s_done_latency: got %0d expected %0d", name, done_edge, NNN + 3); end
    end
    idle_cycles(2);
    checks++; if ({done, busy} !== 2'b00) begin fails++; $display("[TB] FAIL %s_release: got done,busy=%b expected 00", name, {done, busy}); end
  endtask

  // Writes completed strictly before a cut edge: element m writes at edge m*N+N+2
  function automatic int writes_before(input int cut);
    int n;
    n = 0;
    for (int m = 0; m < NN; m++)
      if (m * N + N + 2 < cut) n++;
    return n;
  endfunction

  task automatic test_abort();
    int late;
    run_op(0, 100, -1, 1'b0, 130);
    checks++; if (rd_e_q.size() != 99) begin fails++; $display("[TB] FAIL abort_rd_count: got %0d expected 99", rd_e_q.size()); end
    checks++; if (wr_q.size() != writes_before(100)) begin fails++; $display("[TB] FAIL abort_wr_count: got %0d expected %0d", wr_q.size(), writes_before(100)); end
    late = 0;
    foreach (rd_e_q[x]) if (rd_e_q[x] >= 100) late++;
    foreach (wr_e_q[x]) if (wr_e_q[x] >= 100) late++;
    foreach (mac_e_q[x]) if (mac_e_q[x] >= 100) late++;
    checks++; if (late != 0) begin fails++; $display("[TB] FAIL abort_late_strobes: got %0d expected 0", late); end
    checks++; if (done_edge != -1) begin fails++; $display("[TB] FAIL abort_done: got edge %0d expected none", done_edge); end
    checks++; if ({busy, done} !== 2'b00) begin fails++; $display("[TB] FAIL abort_idle: got busy,done=%b expected 00", {busy, done}); end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid();
    int late;
    run_op(0, -1, 300, 1'b0, 330);
    checks++; if (snap_zero !== 1'b1) begin fails++; $display("[TB] FAIL midreset_outputs_zero: got %b expected 1", snap_zero); end
    checks++; if (snap_cc != 0) begin fails++; $display("[TB] FAIL midreset_count: got %0d expected 0", snap_cc); end
    checks++; if (wr_q.size() != writes_before(300)) begin fails++; $display("[TB] FAIL midreset_wr_count: got %0d expected %0d", wr_q.size(), writes_before(300)); end
    late = 0;
    foreach (rd_e_q[x]) if (rd_e_q[x] >= 300) late++;
    foreach (wr_e_q[x]) if (wr_e_q[x] >= 300) late++;
    checks++; if (late != 0) begin fails++; $display("[TB] FAIL midreset_late_strobes: got %0d expected 0", late); end
    checks++; if (done_edge != -1) begin fails++; $display("[TB] FAIL midreset_done: got edge %0d expected none", done_edge); end
    idle_cycles(2);
  endtask

  task automatic test_start_held();
    int bad;
    run_op(0, -1, -1, 1'b1, 4000);
    checks++; if (done_edge != NNN + 3) begin fails++; $display("[TB] FAIL held_done_edge: got %0d expected %0d", done_edge, NNN + 3); end
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done !== 1'b1 || rd_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin fails++; $display("[TB] FAIL held_no_retrigger: got %0d bad cycles expected 0", bad); end
    start = 1'b0;
    idle_cycles(2);
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL held_done_drop: got %b expected 0", done); end
    idle_cycles(1);
    test_full_run("restart", 0);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    stall  = 1'b0;
    test_reset();
    test_full_run("plain", 0);
    test_full_run("stall3", 1);
    test_full_run("randstall", 2);
    test_abort();
    test_full_run("after_abort", 0);
    test_reset_mid();
    test_start_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
